// File: rtl/countdown_pkg.sv
// rtl/countdown_pkg.sv - shared constants and FSM state type for the countdown timer
package countdown_pkg;

  localparam int SEC_MAX_D = 59;
  localparam int MIN_MAX_D = 59;
  localparam int HRS_MAX_D = 23;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/countdown_timer_if.sv
// rtl/countdown_timer_if.sv - control and count bus of the countdown timer
interface countdown_timer_if #(parameter int W = 32);

  logic         io_en;
  logic         io_load;
  logic [W-1:0] io_load_sec;
  logic [W-1:0] io_load_min;
  logic [W-1:0] io_load_hrs;
  logic         io_start;
  logic [W-1:0] io_count_sec;
  logic [W-1:0] io_count_min;
  logic [W-1:0] io_count_hrs;
  logic         io_borrow_sec;
  logic         io_borrow_min;
  logic         io_busy;
  logic         io_done;

  modport master (
    output io_en, io_load, io_load_sec, io_load_min, io_load_hrs, io_start,
    input  io_count_sec, io_count_min, io_count_hrs,
    input  io_borrow_sec, io_borrow_min, io_busy, io_done
  );

  modport slave (
    input  io_en, io_load, io_load_sec, io_load_min, io_load_hrs, io_start,
    output io_count_sec, io_count_min, io_count_hrs,
    output io_borrow_sec, io_borrow_min, io_busy, io_done
  );

endinterface

// File: rtl/countdown_timer_down_field.sv
// rtl/countdown_timer_down_field.sv - one clamped, wrapping down-counting time field
module down_field #(
  parameter int           W   = 32,
  parameter logic [W-1:0] MAX = W'(59)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         dec,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         borrow_out
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= (load_val > MAX) ? MAX : load_val;
    end else if (dec) begin
      value <= (value == '0) ? MAX : value - W'(1);
    end
  end

  // Borrow feeds the next field's dec in the same cycle.
  assign borrow_out = dec && (value == '0);

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - hh:mm:ss countdown timer; COUNTDOWN_PRESCALE_EN adds a tick prescaler
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int SEC_MAX  = SEC_MAX_D,
  parameter int MIN_MAX  = MIN_MAX_D,
  parameter int HRS_MAX  = HRS_MAX_D,
`ifdef COUNTDOWN_PRESCALE_EN
  parameter int PRESCALE = 100,
`endif
  parameter int W        = 32
) (
  input  logic io_clock,
  input  logic io_reset,
  countdown_timer_if.slave bus
);

  state_t       state, next_state;
  logic [W-1:0] sec_val, min_val, hrs_val;
  logic         sec_borrow, min_borrow, hrs_borrow;
  logic         tick, dec_sec, counts_zero, last_tick, start_ok;
  logic         borrow_sec_q, borrow_min_q, busy_q, done_q;

  assign counts_zero = (sec_val == '0) && (min_val == '0) && (hrs_val == '0);
  assign start_ok    = bus.io_start && !bus.io_load && (state == IDLE);

`ifdef COUNTDOWN_PRESCALE_EN
  logic [31:0] psc;

  assign tick = bus.io_en && (state == RUN) && (psc == 32'(PRESCALE - 1));

  always_ff @(posedge io_clock or negedge io_reset) begin
    if (!io_reset) begin
      psc <= '0;
    end else if (bus.io_load || start_ok) begin
      psc <= '0;
    end else if (bus.io_en && (state == RUN)) begin
      psc <= (psc == 32'(PRESCALE - 1)) ? '0 : psc + 32'd1;
    end
  end
`else
  assign tick = bus.io_en && (state == RUN);
`endif

  assign dec_sec   = tick && !bus.io_load;
  // The tick that lands on 00:00:00 enters DONE on the same edge.
  assign last_tick = dec_sec && (sec_val == W'(1)) && (min_val == '0) && (hrs_val == '0);

  down_field #(.W(W), .MAX(W'(SEC_MAX))) u_sec (
    .clk(io_clock), .rst_n(io_reset), .dec(dec_sec), .load(bus.io_load),
    .load_val(bus.io_load_sec), .value(sec_val), .borrow_out(sec_borrow)
  );

  down_field #(.W(W), .MAX(W'(MIN_MAX))) u_min (
    .clk(io_clock), .rst_n(io_reset), .dec(sec_borrow), .load(bus.io_load),
    .load_val(bus.io_load_min), .value(min_val), .borrow_out(min_borrow)
  );

  down_field #(.W(W), .MAX(W'(HRS_MAX))) u_hrs (
    .clk(io_clock), .rst_n(io_reset), .dec(min_borrow), .load(bus.io_load),
    .load_val(bus.io_load_hrs), .value(hrs_val), .borrow_out(hrs_borrow)
  );

  always_ff @(posedge io_clock or negedge io_reset) begin
    if (!io_reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (bus.io_load) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.io_start) next_state = counts_zero ? DONE : RUN;
        RUN:     if (last_tick) next_state = DONE;
        DONE:    next_state = DONE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge io_clock or negedge io_reset) begin
    if (!io_reset) begin
      borrow_sec_q <= 1'b0;
      borrow_min_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      borrow_sec_q <= sec_borrow;
      borrow_min_q <= min_borrow;
      busy_q       <= (next_state == RUN);
      done_q       <= (next_state == DONE);
    end
  end

  assign bus.io_count_sec  = sec_val;
  assign bus.io_count_min  = min_val;
  assign bus.io_count_hrs  = hrs_val;
  assign bus.io_borrow_sec = borrow_sec_q;
  assign bus.io_borrow_min = borrow_min_q;
  assign bus.io_busy       = busy_q;
  assign bus.io_done       = done_q;

  logic unused_hrs_borrow;
  assign unused_hrs_borrow = hrs_borrow;

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - directed self-checking bench for countdown_timer
module tb_countdown_timer;

`ifdef COUNTDOWN_PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  countdown_timer_if #(.W(32)) bus ();

  countdown_timer #(
`ifdef COUNTDOWN_PRESCALE_EN
    .PRESCALE(PS),
`endif
    .W(32)
  ) dut (
    .io_clock(clk),
    .io_reset(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int h, input int m, input int s);
    bus.io_load     = 1'b1;
    bus.io_load_hrs = h;
    bus.io_load_min = m;
    bus.io_load_sec = s;
    step();
    bus.io_load     = 1'b0;
  endtask

  task automatic do_start();
    bus.io_start = 1'b1;
    step();
    bus.io_start = 1'b0;
  endtask

  task automatic tick_once();
    bus.io_en = 1'b1;
    repeat (PS) step();
    bus.io_en = 1'b0;
  endtask

  initial begin
    int cyc;
    int bad;
    n_checks = 0;
    n_pass   = 0;
    bus.io_en = 1'b0; bus.io_load = 1'b0; bus.io_start = 1'b0;
    bus.io_load_sec = '0; bus.io_load_min = '0; bus.io_load_hrs = '0;
    rst_n = 1'b0;
    #2;
    check("rst_sec",  bus.io_count_sec, 0);
    check("rst_busy", bus.io_busy, 0);
    check("rst_done", bus.io_done, 0);
    #1 rst_n = 1'b1;

    // basic 0:0:3 countdown
    do_load(0, 0, 3);
    check("load3_sec", bus.io_count_sec, 3);
    do_start();
    check("start_busy", bus.io_busy, 1);
    check("start_sec", bus.io_count_sec, 3);
    tick_once(); check("cd_sec2", bus.io_count_sec, 2);
    tick_once(); check("cd_sec1", bus.io_count_sec, 1);
    check("cd_done_lo", bus.io_done, 0);
    tick_once(); check("cd_sec0", bus.io_count_sec, 0);
    check("cd_done", bus.io_done, 1);
    check("cd_busy", bus.io_busy, 0);
    do_start();
    check("done_ignores_start", bus.io_done, 1);
    check("done_no_underflow", bus.io_count_sec, 0);

    // seconds wrap with minute borrow
    do_load(0, 1, 0);
    do_start();
    tick_once();
    check("w1_sec", bus.io_count_sec, 59);
    check("w1_min", bus.io_count_min, 0);
    check("w1_bsec", bus.io_borrow_sec, 1);
    check("w1_bmin", bus.io_borrow_min, 0);
    step();
    check("w1_bsec_off", bus.io_borrow_sec, 0);
    check("w1_hold", bus.io_count_sec, 59);

    // hour wrap, both borrows together
    do_load(1, 0, 0);
    do_start();
    tick_once();
    check("w2_hrs", bus.io_count_hrs, 0);
    check("w2_min", bus.io_count_min, 59);
    check("w2_sec", bus.io_count_sec, 59);
    check("w2_bsec", bus.io_borrow_sec, 1);
    check("w2_bmin", bus.io_borrow_min, 1);

    // full hour
    do_load(1, 0, 0);
    do_start();
    bus.io_en = 1'b1;
    cyc = 0;
    while (!bus.io_done && cyc < 4000 * PS) begin
      step();
      cyc++;
    end
    check("hour_cycles", cyc, 3600 * PS);
    bad = 0;
    repeat (20) begin
      step();
      if (bus.io_count_sec != 0 || bus.io_count_min != 0 || bus.io_count_hrs != 0 || !bus.io_done) bad++;
    end
    check("hour_hold_zero", bad, 0);
    bus.io_en = 1'b0;

    // clamp
    do_load(30, 60, 75);
    check("clamp_sec", bus.io_count_sec, 59);
    check("clamp_min", bus.io_count_min, 59);
    check("clamp_hrs", bus.io_count_hrs, 23);

    // load beats start
    do_start();
    check("pre_busy", bus.io_busy, 1);
    bus.io_start = 1'b1;
    do_load(0, 0, 5);
    bus.io_start = 1'b0;
    check("ls_busy", bus.io_busy, 0);
    check("ls_sec", bus.io_count_sec, 5);
    step();
    check("ls_busy2", bus.io_busy, 0);

    // zero load then start
    do_load(0, 0, 0);
    do_start();
    check("zero_done", bus.io_done, 1);
    check("zero_busy", bus.io_busy, 0);

`ifdef COUNTDOWN_PRESCALE_EN
    do_load(0, 0, 2);
    do_start();
    bus.io_en = 1'b1;
    repeat (3) step();
    check("ps_sec_hold", bus.io_count_sec, 2);
    step();
    check("ps_sec1", bus.io_count_sec, 1);
    repeat (3) step();
    check("ps_done_lo", bus.io_done, 0);
    step();
    check("ps_done", bus.io_done, 1);
    bus.io_en = 1'b0;
`endif

    // pause then async reset mid-run
    do_load(0, 0, 10);
    do_start();
    bad = 0;
    repeat (5) begin
      step();
      if (bus.io_count_sec != 10 || !bus.io_busy) bad++;
    end
    check("pause_hold", bad, 0);
    tick_once();
    check("pause_resume", bus.io_count_sec, 9);
    rst_n = 1'b0;
    #1;
    check("arst_sec", bus.io_count_sec, 0);
    check("arst_busy", bus.io_busy, 0);
    check("arst_done", bus.io_done, 0);
    #1 rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
